// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF stage.
// Fetch FSM states, bubble encoding, default reset PC, fetch packet.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: PC, instruction, valid.
// Ports: en/stall/flush control, avail + pkt_i from fetch, PC_ID/inst_ID/valid_ID out.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        flush,
  input  logic        avail,
  input  fetch_pkt_t  pkt_i,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  // Stall (or disable) wins over flush; flush wins over a ready packet.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (en & ~stall) begin
      if (flush | ~avail) begin
        pc_d    = 32'h0;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end else begin
        pc_d    = pkt_i.pc;
        inst_d  = pkt_i.inst;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'h0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign PC_ID    = pc_q;
  assign inst_ID  = inst_q;
  assign valid_ID = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: fetch PC, one-outstanding imem handshake, hold buffer, IF/ID reg.
// Ports: hazard controls, branch redirect, imem req/resp, PC_ID/inst_ID/valid_ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_EN_IF,
  input  logic        reg_FD_EN,
  input  logic        reg_FD_stall,
  input  logic        reg_FD_flush,
  input  logic        Branch_ID,
  input  logic [31:0] PC_branch_ID,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_fetch_q, pc_fetch_d;
  logic [31:0]  pc_inflight_q, pc_inflight_d;
  logic         drop_q, drop_d;
  fetch_pkt_t   hold_q, hold_d;

  logic       redirect;
  logic       fd_load;
  logic       resp_ok;
  logic       avail;
  logic       take;
  fetch_pkt_t resp_pkt;
  fetch_pkt_t fd_pkt;

  assign redirect = Branch_ID & PC_EN_IF;
  assign fd_load  = reg_FD_EN & ~reg_FD_stall;
  assign resp_ok  = (state_q == S_WAIT) & imem_resp_valid
                  & ~drop_q & ~redirect;
  assign avail    = (state_q == S_HOLD) | resp_ok;
  // A flush while a packet is available leaves it pending.
  assign take     = fd_load & ~reg_FD_flush & avail;
  assign resp_pkt = '{pc: pc_inflight_q, inst: imem_resp_data};
  assign fd_pkt   = (state_q == S_HOLD) ? hold_q : resp_pkt;
  assign imem_addr = pc_fetch_q;

  always_comb begin
    state_d        = state_q;
    pc_fetch_d     = pc_fetch_q;
    pc_inflight_d  = pc_inflight_q;
    drop_d         = drop_q;
    hold_d         = hold_q;
    imem_req_valid = 1'b0;
    if (redirect) pc_fetch_d = PC_branch_ID;
    unique case (state_q)
      S_REQ: begin
        imem_req_valid = PC_EN_IF & ~redirect;
        if (PC_EN_IF & ~redirect & imem_req_ready) begin
          pc_inflight_d = pc_fetch_q;
          pc_fetch_d    = pc_fetch_q + 32'd4;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q | redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (take) begin
            state_d = S_REQ;
          end else begin
            hold_d  = resp_pkt;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          // Response still owed: squash it on arrival.
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect | take) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_fetch_q    <= RESET_PC;
      pc_inflight_q <= 32'h0;
      drop_q        <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_fetch_q    <= pc_fetch_d;
      pc_inflight_q <= pc_inflight_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .en      (reg_FD_EN),
    .stall   (reg_FD_stall),
    .flush   (reg_FD_flush),
    .avail   (avail),
    .pkt_i   (fd_pkt),
    .PC_ID   (PC_ID),
    .inst_ID (inst_ID),
    .valid_ID(valid_ID)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a behavioural imem.
// Stimulus pushes accepted fetches; a monitor pops on IF/ID loads.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_EN_IF = 1'b0;
  logic        reg_FD_EN = 1'b0;
  logic        reg_FD_stall = 1'b0;
  logic        reg_FD_flush = 1'b0;
  logic        Branch_ID = 1'b0;
  logic [31:0] PC_branch_ID = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic [31:0] PC_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .PC_EN_IF       (PC_EN_IF),
    .reg_FD_EN      (reg_FD_EN),
    .reg_FD_stall   (reg_FD_stall),
    .reg_FD_flush   (reg_FD_flush),
    .Branch_ID      (Branch_ID),
    .PC_branch_ID   (PC_branch_ID),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .PC_ID          (PC_ID),
    .inst_ID        (inst_ID),
    .valid_ID       (valid_ID)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int deliveries = 0;

  fetch_pkt_t  exp_q[$];
  logic [31:0] fetch_pc = 32'h0;
  bit          outstanding = 1'b0;
  int          cnt = 0;
  logic [31:0] infl_addr = 32'h0;
  int          lat_fix = 1;
  bit          last_load = 1'b0;
  bit          last_flush = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle window: drive at negedge, observe request side before posedge.
  task automatic step(input bit en_pc, input bit fd_en, input bit stall,
                      input bit flush, input bit br,
                      input logic [31:0] tgt, input bit rdy);
    bit resp_now;
    bit redirect;
    bit accept;
    bit was_out;
    @(negedge clk);
    resp_now = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = $urandom;
    if (outstanding && cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem(infl_addr);
        resp_now = 1'b1;
      end
    end
    PC_EN_IF = en_pc;
    reg_FD_EN = fd_en;
    reg_FD_stall = stall;
    reg_FD_flush = flush | br;
    Branch_ID = br;
    PC_branch_ID = tgt;
    imem_req_ready = rdy;
    #1;
    redirect = br & en_pc;
    accept = imem_req_valid & imem_req_ready;
    if (!en_pc || redirect) chk("req_gated", 32'(imem_req_valid), 0);
    was_out = outstanding;
    if (accept) begin
      chk("one_outstanding", 32'(was_out), 0);
      chk("req_addr", imem_addr, fetch_pc);
      exp_q.push_back('{pc: imem_addr, inst: mem(imem_addr)});
      fetch_pc = imem_addr + 32'd4;
      infl_addr = imem_addr;
      outstanding = 1'b1;
      cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end else if (resp_now) begin
      outstanding = 1'b0;
    end
    if (redirect) begin
      exp_q.delete();
      fetch_pc = tgt;
    end
    last_load = fd_en & ~stall;
    last_flush = flush | br;
  endtask

  task automatic do_reset(input bit stale);
    @(negedge clk);
    rst = 1'b1;
    PC_EN_IF = 0; reg_FD_EN = 0; reg_FD_stall = 0; reg_FD_flush = 0;
    Branch_ID = 0; PC_branch_ID = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0;
    last_load = 0; last_flush = 0;
    #1;
    chk("rst_valid_async", 32'(valid_ID), 0);
    chk("rst_inst_async", inst_ID, 32'h0000_0013);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    outstanding = 0;
    cnt = 0;
    exp_q.delete();
    fetch_pc = 32'h0;
    if (stale) begin
      // Leftover response from before reset, arriving in S_REQ.
      imem_resp_valid = 1'b1;
      imem_resp_data = 32'hDEAD_BEEF;
      PC_EN_IF = 1; reg_FD_EN = 1;
      last_load = 1;
    end
  endtask

  // Monitor: checks IF/ID after every active edge.
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_inst = 32'h13;
  logic        prev_valid = 1'b0;

  initial begin
    fetch_pkt_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_valid", 32'(valid_ID), 0);
        chk("rst_pc", PC_ID, 0);
        chk("rst_inst", inst_ID, 32'h13);
      end else if (last_load && !last_flush && valid_ID) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pc", PC_ID, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", PC_ID, e.pc);
          chk("id_inst", inst_ID, e.inst);
          deliveries++;
        end
      end else if (last_load) begin
        chk("bubble_valid", 32'(valid_ID), 0);
        chk("bubble_pc", PC_ID, 0);
        chk("bubble_inst", inst_ID, 32'h13);
      end else begin
        chk("hold_valid", 32'(valid_ID), 32'(prev_valid));
        chk("hold_pc", PC_ID, prev_pc);
        chk("hold_inst", inst_ID, prev_inst);
      end
      prev_pc = PC_ID;
      prev_inst = inst_ID;
      prev_valid = valid_ID;
    end
  end

  initial begin
    int d0;
    do_reset(1'b0);

    // Straight-line fetch at full rate with 1-cycle imem.
    lat_fix = 1;
    d0 = deliveries;
    repeat (20) step(1, 1, 0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    chk("throughput", deliveries - d0, 10);

    // Response lands during a 3-cycle load-use stall.
    step(1, 1, 0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 1, 0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0, 0, 0, 1);

    // Redirect while waiting; stale response arrives next cycle.
    lat_fix = 2;
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1, 32'h100, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    lat_fix = 1;
    repeat (4) step(1, 1, 0, 0, 0, 0, 1);

    // Flush coincident with a response.
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0, 0, 0, 1);

    // imem not ready with PC_EN_IF toggling.
    for (int i = 0; i < 4; i++) step(1'(i % 2 == 0), 1, 0, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0, 0, 1);

    // Reset while a request is in flight.
    lat_fix = 3;
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    do_reset(1'b1);
    lat_fix = 1;
    repeat (6) step(1, 1, 0, 0, 0, 0, 1);

    // Randomized traffic.
    lat_fix = 0;
    d0 = deliveries;
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 24) == 0),
           32'($urandom_range(0, 1023)) << 2,
           1'($urandom_range(0, 9) < 7));
    end
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    chk("liveness", 32'(deliveries - d0 >= 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
